// File: rtl/div_ctrl.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and the W forms.
// The request is latched at accept and the operands are conditioned in PREP.
// Divide-by-zero and signed overflow skip the iteration.
// Otherwise there is one CALC cycle per quotient bit, then the signs are fixed up in FIX.
// The result is held in DONE until it is accepted.
module div_ctrl #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      div_op,
  input  logic [XLEN-1:0] div_src1,
  input  logic [XLEN-1:0] div_src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] div_result,
  output logic            busy
);

  localparam int unsigned HALF = XLEN / 2;
  localparam int unsigned CW   = $clog2(XLEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [7:0]      op_q, op_d;
  logic [XLEN-1:0] src1_q, src1_d;
  logic [XLEN-1:0] src2_q, src2_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            out_valid_q, out_valid_d;

  // Decode of the latched op: {div,divu,rem,remu,divw,divuw,remw,remuw}
  logic is_w, is_sgn, is_rem;
  assign is_w   = |op_q[3:0];
  assign is_sgn = op_q[7] | op_q[5] | op_q[3] | op_q[1];
  assign is_rem = op_q[5] | op_q[4] | op_q[1] | op_q[0];

  // Operand conditioning used in PREP
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, min_val, spec_val;
  logic            a_neg, b_neg, div0, ovf;

  assign a_ext = !is_w ? src1_q :
                 is_sgn ? {{HALF{src1_q[HALF-1]}}, src1_q[HALF-1:0]} :
                          {{HALF{1'b0}}, src1_q[HALF-1:0]};
  assign b_ext = !is_w ? src2_q :
                 is_sgn ? {{HALF{src2_q[HALF-1]}}, src2_q[HALF-1:0]} :
                          {{HALF{1'b0}}, src2_q[HALF-1:0]};
  assign a_neg   = is_sgn & a_ext[XLEN-1];
  assign b_neg   = is_sgn & b_ext[XLEN-1];
  assign a_abs   = a_neg ? (~a_ext + 1'b1) : a_ext;
  assign b_abs   = b_neg ? (~b_ext + 1'b1) : b_ext;
  assign min_val = is_w ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
  assign div0    = (b_ext == '0);
  assign ovf     = is_sgn & (&b_ext) & (a_ext == min_val);
  assign spec_val = div0 ? (is_rem ? a_ext : '1) : (is_rem ? '0 : a_ext);

  // One restoring step: shift {rem,quo} left and try to subtract the divisor
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] trial;
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign trial   = {1'b0, shifted} - {2'b00, dvs_q};

  // Sign fix-up and selection
  logic [XLEN-1:0] q_fix, r_fix, sel_fix;
  assign q_fix   = negq_q ? (~quo_q + 1'b1) : quo_q;
  assign r_fix   = negr_q ? (~rem_q + 1'b1) : rem_q;
  assign sel_fix = is_rem ? r_fix : q_fix;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_PREP;
      S_PREP:  state_d = (div0 | ovf) ? S_DONE : S_CALC;
      S_CALC:  if (cnt_q == CW'(1)) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  if (out_valid_q & out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // FSM outputs
  always_comb begin
    busy     = (state_q != S_IDLE);
    in_ready = (state_q == S_IDLE) & ~flush;
  end

  // Datapath next-state
  always_comb begin
    op_d     = op_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid & in_ready) begin
          op_d   = div_op;
          src1_d = div_src1;
          src2_d = div_src2;
        end
      end
      S_PREP: begin
        if (div0 | ovf) begin
          result_d = is_w ? {{HALF{spec_val[HALF-1]}}, spec_val[HALF-1:0]} : spec_val;
        end else begin
          rem_d  = '0;
          // W dividends sit in the upper half so the same MSB-first shift applies
          quo_d  = is_w ? {a_abs[HALF-1:0], {HALF{1'b0}}} : a_abs;
          dvs_d  = b_abs;
          cnt_d  = is_w ? CW'(HALF) : CW'(XLEN);
          negq_d = a_neg ^ b_neg;
          negr_d = a_neg;
        end
      end
      S_CALC: begin
        if (!trial[XLEN+1]) begin
          rem_d = trial[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = shifted[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
      end
      S_FIX: begin
        result_d = is_w ? {{HALF{sel_fix[HALF-1]}}, sel_fix[HALF-1:0]} : sel_fix;
      end
      default: ;
    endcase
  end

  // out_valid rises the cycle after DONE is entered and drops on handshake or flush
  always_comb begin
    out_valid_d = (state_q == S_DONE) & ~(out_valid_q & out_ready) & ~flush;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q        <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      op_q        <= op_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      negq_q      <= negq_d;
      negr_q      <= negr_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign div_result = result_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl.
// It runs directed cases, then randomized ops against an arithmetic reference model.
module tb_div_ctrl;

  localparam logic [7:0] OP_DIV   = 8'h80;
  localparam logic [7:0] OP_DIVU  = 8'h40;
  localparam logic [7:0] OP_REM   = 8'h20;
  localparam logic [7:0] OP_REMU  = 8'h10;
  localparam logic [7:0] OP_DIVW  = 8'h08;
  localparam logic [7:0] OP_DIVUW = 8'h04;
  localparam logic [7:0] OP_REMW  = 8'h02;
  localparam logic [7:0] OP_REMUW = 8'h01;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  div_op = '0;
  logic [63:0] div_src1 = '0;
  logic [63:0] div_src2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] div_result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  div_ctrl #(.XLEN(64)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .div_op(div_op),
    .div_src1(div_src1), .div_src2(div_src2),
    .out_valid(out_valid), .out_ready(out_ready),
    .div_result(div_result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V divide semantics using plain language arithmetic
  task automatic model(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] res, output int lat);
    bit          w, s, r, special;
    longint      sa, sb;
    int          sa32, sb32;
    logic [63:0] q, m;
    logic [31:0] a32, b32, q32, m32, x32;
    w = |op[3:0];
    s = op[7] | op[5] | op[3] | op[1];
    r = op[5] | op[4] | op[1] | op[0];
    special = 1'b0;
    if (!w) begin
      sa = a; sb = b;
      if (b == 64'd0) begin q = '1; m = a; special = 1'b1; end
      else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; m = '0; special = 1'b1; end
      else if (s) begin q = sa / sb; m = sa % sb; end
      else begin q = a / b; m = a % b; end
      res = r ? m : q;
    end else begin
      a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
      if (b32 == 32'd0) begin q32 = '1; m32 = a32; special = 1'b1; end
      else if (s && a32 == 32'h8000_0000 && b32 == '1) begin q32 = a32; m32 = '0; special = 1'b1; end
      else if (s) begin q32 = sa32 / sb32; m32 = sa32 % sb32; end
      else begin q32 = a32 / b32; m32 = a32 % b32; end
      x32 = r ? m32 : q32;
      res = {{32{x32[31]}}, x32};
    end
    lat = special ? 2 : (w ? 35 : 67);
  endtask

  // Drive a request at the negedge; returns #1 after the accept edge T0
  task automatic issue(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    div_op = op; div_src1 = a; div_src2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; div_op = '0;
  endtask

  // Count edges after T0 until out_valid, bounded
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic handshake(input string tag);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check({tag, "_ov_drop"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic run_core(input string tag, input logic [7:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int lat);
    int cyc;
    issue(op, a, b);
    check({tag, "_busy"}, {63'd0, busy}, 64'd1);
    check({tag, "_inrdy"}, {63'd0, in_ready}, 64'd0);
    wait_valid(cyc);
    check({tag, "_lat"}, 64'(cyc), 64'(lat));
    check({tag, "_res"}, div_result, exp);
    handshake(tag);
  endtask

  task automatic run_rand(input string tag, input logic [7:0] op, input logic [63:0] a,
                          input logic [63:0] b);
    logic [63:0] exp;
    int lat;
    model(op, a, b, exp, lat);
    run_core(tag, op, a, b, exp, lat);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_8000_0000;
      4: return 64'($urandom_range(0, 20));
      5: return {32'd0, $urandom()};
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    logic [63:0] exp;
    logic [7:0]  ops [8];
    int          lat, cyc;
    ops = '{OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};

    // Reset state
    #12;
    check("rst_ov", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_res", div_result, 64'd0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    check("rst_inrdy", {63'd0, in_ready}, 64'd1);

    // Directed cases
    run_core("divu_100_7", OP_DIVU, 64'd100, 64'd7, 64'd14, 67);
    run_core("remu_100_7", OP_REMU, 64'd100, 64'd7, 64'd2, 67);
    run_core("div_m7_2", OP_DIV, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 67);
    run_core("rem_m7_2", OP_REM, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 67);
    run_core("divu_by0", OP_DIVU, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2);
    run_core("rem_by0", OP_REM, 64'd5, 64'd0, 64'd5, 2);
    run_core("remw_by0", OP_REMW, 64'h1_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 2);
    run_core("div_ovf", OP_DIV, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 2);
    run_core("rem_ovf", OP_REM, 64'h8000_0000_0000_0000, '1, 64'd0, 2);
    run_core("divw_ovf", OP_DIVW, 64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 2);
    run_core("divuw", OP_DIVUW, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 35);
    run_core("remw_m9_4", OP_REMW, -64'sd9, 64'd4, 64'hFFFF_FFFF_FFFF_FFFF, 35);

    // Backpressure: result and out_valid stable, in_ready low
    model(OP_DIV, 64'd1000003, -64'sd17, exp, lat);
    issue(OP_DIV, 64'd1000003, -64'sd17);
    wait_valid(cyc);
    check("bp_lat", 64'(cyc), 64'(lat));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_ov", {63'd0, out_valid}, 64'd1);
      check("bp_res", div_result, exp);
      check("bp_inrdy", {63'd0, in_ready}, 64'd0);
    end
    handshake("bp");

    // Flush in CALC, then a new op right away
    issue(OP_DIVU, 64'hDEAD_BEEF_0000_1234, 64'd3);
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("fl_busy", {63'd0, busy}, 64'd0);
    check("fl_ov", {63'd0, out_valid}, 64'd0);
    run_rand("fl_next", OP_REMU, 64'hDEAD_BEEF_0000_1234, 64'd1000);

    // Flush in IDLE blocks a simultaneous request
    @(negedge clk); flush = 1'b1; in_valid = 1'b1; div_op = OP_DIVU;
    div_src1 = 64'd9; div_src2 = 64'd0;
    #1 check("fl_idle_inrdy", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0; div_op = '0;
    check("fl_idle_busy", {63'd0, busy}, 64'd0);

    // Flush together with handshake discards the result
    issue(OP_DIVU, 64'd77, 64'd0);
    wait_valid(cyc);
    check("fl_hs_lat", 64'(cyc), 64'd2);
    @(negedge clk); flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; flush = 1'b0; out_ready = 1'b0;
    check("fl_hs_ov", {63'd0, out_valid}, 64'd0);
    check("fl_hs_busy", {63'd0, busy}, 64'd0);

    // Reset pulse mid-CALC
    issue(OP_DIV, 64'd123456789, 64'd11);
    repeat (10) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("mr_busy", {63'd0, busy}, 64'd0);
    check("mr_ov", {63'd0, out_valid}, 64'd0);
    check("mr_res", div_result, 64'd0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    check("mr_inrdy", {63'd0, in_ready}, 64'd1);
    check("mr_ov2", {63'd0, out_valid}, 64'd0);
    run_rand("mr_next", OP_DIV, 64'd123456789, 64'd11);

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      run_rand("rnd", ops[$urandom_range(0, 7)], pick(), pick());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
